// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle arithmetic/logic, with shifts done one bit per cycle.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_iterative #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam int SW = $clog2(WIDTH);

   // Undefined codes (1010-1111) fall through to ADD.
   function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
      logic [SW-1:0] sh;
      sh = y[SW-1:0];
      case (op)
         4'b0001: return x - y;
         4'b0010: return x & y;
         4'b0011: return x | y;
         4'b0100: return x ^ y;
         4'b0101: return {{(WIDTH-1){1'b0}}, $signed(x) < $signed(y)};
         4'b0110: return x << sh;
         4'b0111: return x >> sh;
         4'b1000: return $signed(x) >>> sh;
         4'b1001: return {{(WIDTH-1){1'b0}}, x < y};
         default: return x + y;
      endcase
   endfunction

`ifdef ALU_FAST_SHIFT_EN

   logic [WIDTH-1:0] op_res;

   assign op_res = alu_op(alu_ctrl, a, b);
   assign busy   = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         zero   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            result <= op_res;
            zero   <= (op_res == '0);
            done   <= 1'b1;
         end
      end
   end

`else

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] work, work_sh, op_res;
   logic [3:0]       sh_op;
   logic [SW-1:0]    cnt, shamt;
   logic             is_shift;

   assign shamt    = b[SW-1:0];
   assign is_shift = (alu_ctrl == 4'b0110) || (alu_ctrl == 4'b0111) || (alu_ctrl == 4'b1000);
   assign op_res   = alu_op(alu_ctrl, a, b);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start && is_shift && (shamt != '0)) state_nxt = SHIFT;
         SHIFT: if (cnt == SW'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == SHIFT);
   end

   // One bit position per cycle; the fill bit depends on the latched opcode.
   always_comb begin
      work_sh = work;
      case (sh_op)
         4'b0110: work_sh = {work[WIDTH-2:0], 1'b0};
         4'b0111: work_sh = {1'b0, work[WIDTH-1:1]};
         4'b1000: work_sh = {work[WIDTH-1], work[WIDTH-1:1]};
         default: work_sh = work;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         zero   <= 1'b0;
         done   <= 1'b0;
         work   <= '0;
         sh_op  <= '0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (!is_shift) begin
                     result <= op_res;
                     zero   <= (op_res == '0);
                     done   <= 1'b1;
                  end else begin
                     work  <= a;
                     sh_op <= alu_ctrl;
                     cnt   <= shamt;
                     if (shamt == '0) begin
                        result <= a;
                        zero   <= (a == '0);
                        done   <= 1'b1;
                     end
                  end
               end
            end
            SHIFT: begin
               work <= work_sh;
               cnt  <= cnt - SW'(1);
               if (cnt == SW'(1)) begin
                  result <= work_sh;
                  zero   <= (work_sh == '0);
                  done   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`endif

endmodule

// File: tb/tb_alu_iterative.sv
// Bench for alu_iterative: a cycle-level behavioural model checked every cycle,
// plus directed cases with hand-computed expectations.
module tb_alu_iterative;
   localparam int W = 32;
`ifdef ALU_FAST_SHIFT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [3:0]   alu_ctrl = 4'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] result;
   logic         zero, busy, done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_iterative #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl),
      .a(a), .b(b), .result(result), .zero(zero), .busy(busy), .done(done)
   );

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_op(input logic [3:0] c, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
      int n;
      n = int'(y[4:0]);
      case (c)
         4'd1:    return x - y;
         4'd2:    return x & y;
         4'd3:    return x | y;
         4'd4:    return x ^ y;
         4'd5:    return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
         4'd6:    return x << n;
         4'd7:    return x >> n;
         4'd8:    return $signed(x) >>> n;
         4'd9:    return (x < y) ? W'(1) : W'(0);
         default: return x + y;
      endcase
   endfunction

   // Model: an op either completes at the accepting edge, or occupies the unit for shamt edges.
   logic [W-1:0] exp_result = '0;
   logic         exp_zero = 1'b0, exp_done = 1'b0, exp_busy = 1'b0;
   int           m_left = 0;
   int           m_n;
   logic [W-1:0] m_pend, m_r;
   bit           m_sh;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_result = '0; exp_zero = 1'b0; exp_done = 1'b0; exp_busy = 1'b0; m_left = 0;
      end else begin
         exp_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               exp_result = m_pend; exp_zero = (m_pend == '0); exp_done = 1'b1;
            end
         end else if (start) begin
            m_r  = ref_op(alu_ctrl, a, b);
            m_n  = int'(b[4:0]);
            m_sh = (alu_ctrl == 4'd6) || (alu_ctrl == 4'd7) || (alu_ctrl == 4'd8);
            if (m_sh && m_n > 0 && !FAST) begin
               m_left = m_n; m_pend = m_r;
            end else begin
               exp_result = m_r; exp_zero = (m_r == '0); exp_done = 1'b1;
            end
         end
         exp_busy = (m_left > 0);
      end
   end

   always @(negedge clk) begin
      chk("cyc_result", result, exp_result);
      chk("cyc_zero", W'(zero), W'(exp_zero));
      chk("cyc_done", W'(done), W'(exp_done));
      chk("cyc_busy", W'(busy), W'(exp_busy));
   end

   task automatic issue(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
      @(posedge clk); #1;
      start = 1'b1; alu_ctrl = c; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int nbusy);
      lat = 0; nbusy = 0;
      repeat (40) begin
         @(negedge clk);
         lat++;
         if (done) return;
         if (busy) nbusy++;
      end
      checks++; errors++;
      $display("FAIL wait_done timeout after %0d cycles, required a done pulse", lat);
   endtask

   int lat, nb;

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_result", result, '0);
      chk("reset_busy", W'(busy), '0);
      chk("reset_done", W'(done), '0);

      issue(4'd0, 32'h0000_0005, 32'hFFFF_FFFB);
      wait_done(lat, nb);
      chk("add_lat", W'(lat), W'(1));
      chk("add_result", result, '0);
      chk("add_zero", W'(zero), W'(1));

      issue(4'd5, 32'hFFFF_FFFF, 32'h1);
      wait_done(lat, nb);
      chk("slt_result", result, W'(1));
      chk("slt_zero", W'(zero), W'(0));

      issue(4'd9, 32'hFFFF_FFFF, 32'h1);
      wait_done(lat, nb);
      chk("sltu_result", result, W'(0));
      chk("sltu_zero", W'(zero), W'(1));

      issue(4'd8, 32'h8000_0000, 32'd31);
      wait_done(lat, nb);
      chk("sra_result", result, 32'hFFFF_FFFF);
      chk("sra_busy_cycles", W'(nb), FAST ? W'(0) : W'(31));
      chk("sra_lat", W'(lat), FAST ? W'(1) : W'(32));

      issue(4'd6, 32'h1234_5678, 32'h20);
      wait_done(lat, nb);
      chk("sll0_result", result, 32'h1234_5678);
      chk("sll0_busy", W'(nb), W'(0));
      chk("sll0_lat", W'(lat), W'(1));

`ifndef ALU_FAST_SHIFT_EN
      @(posedge clk); #1;
      start = 1'b1; alu_ctrl = 4'd7; a = 32'hF0; b = 32'd4;
      @(posedge clk); #1;
      alu_ctrl = 4'd0; a = 32'h1; b = 32'h1;
      @(posedge clk); #1;
      start = 1'b0; alu_ctrl = 4'd3; a = 32'h0; b = 32'h0;
      wait_done(lat, nb);
      chk("hs_ignored_result", result, 32'h0F);
      start = 1'b1; alu_ctrl = 4'd4; a = 32'hFF; b = 32'h0F;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("hs_b2b_done", W'(done), W'(1));
      chk("hs_b2b_result", result, 32'hF0);
`endif

      issue(4'd6, 32'h1, 32'd10);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_mid_result", result, '0);
      chk("rst_mid_busy", W'(busy), '0);
      chk("rst_mid_done", W'(done), '0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (15) begin
         @(negedge clk);
         chk("no_done_after_rst", W'(done), '0);
      end

      issue(4'd15, 32'd2, 32'd3);
      wait_done(lat, nb);
      chk("invalid_code_add", result, 32'd5);

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (i == 1500) rst = 1'b1;
         if (i == 1502) rst = 1'b0;
         start    = 1'($urandom_range(0, 1));
         alu_ctrl = 4'($urandom_range(0, 15));
         b        = $urandom;
         if ($urandom_range(0, 3) == 0) b[4:0] = 5'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: a = $urandom;
            1: a = '0;
            2: a = b;
            default: a = 32'h8000_0000 | $urandom;
         endcase
      end
      @(posedge clk); #1 start = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
